debounce_sched: RTL and testbench
=================================

# debounce_sched

Multi-channel debounce controller: time-shares one sampling prescaler across `N_CH` raw switch inputs, keeps a per-channel integrator, and serializes every debounced edge into a single event stream. A round-robin arbiter drives a valid/ready interface. It sits between board switches/buttons and the UART/command logic, replacing per-button free-running debounce FSMs.

## Interface
- `N_CH`, 4: number of switch channels (2..16).
- `P`, 16: prescaler width. Sample tick every 2^P cycles (1.31 ms at 50 MHz).
- `K`, 4: consecutive differing samples required to toggle a level (2..15).
- `CW`, `$clog2(N_CH)`: channel index width (derived localparam).

- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `sw` in N_CH: raw switch inputs.
- `db_level` out N_CH: debounced levels.
- `ev_valid` out 1: event available.
- `ev_ready` in 1: consumer accepts event.
- `ev_ch` out CW: channel of the current event.
- `ev_rise` out 1: 1 = rising edge, 0 = falling edge.
- `ovf` out N_CH: sticky overrun flags.
- `ovf_clr` in 1: clears all `ovf` bits.

## Operation
- **Prescaler**
  - `presc` (P bits) counts up every cycle and wraps at 2^P−1.
  - `tick` is high only in the cycle where `presc == 2^P−1`.
- **Per-channel integrator**
  - Counter `cnt` is ceil(log2 K) bits; it changes only on `tick`.
  - On `tick`, if `sw[i] == db_level[i]`: set `cnt` to 0.
  - On `tick`, if `sw[i] != db_level[i]` and `cnt == K−1`:
    - toggle `db_level[i]`, set `cnt` to 0;
    - raise a one-cycle `evt[i]` with polarity equal to the new level.
  - On `tick`, otherwise: increment `cnt`.
  - A level therefore toggles on the K-th consecutive differing sample. Any agreeing sample restarts the count.
- **Pending slots**
  - Each channel has one slot: `pend[i]` and `pol[i]`.
  - `evt[i]` sets `pend[i]` and writes `pol[i]`.
  - If `pend[i]` is already set and is not being granted in the same cycle:
    - the polarity is overwritten with the newest value;
    - `ovf[i]` is set.
  - `ovf_clr` clears all bits. If a set and a clear happen in the same cycle, the set wins.
- **Arbiter**
  - The output register is free when `!ev_valid`, or when `ev_valid && ev_ready`.
  - When free and any `pend` is set, grant the first pending channel searching from `last+1` upward, wrapping modulo N_CH.
  - On grant, the next edge loads `ev_ch` and `ev_rise = pol[g]`, sets `ev_valid`, clears `pend[g]`, and sets `last = g`.
  - When the handshake completes and nothing is pending, `ev_valid` falls on the next edge.
  - If a channel is granted in the same cycle its new `evt` arrives, the new event stays pending. It is not lost and does not set `ovf`.
  - `ev_ch` and `ev_rise` are held stable while `ev_valid && !ev_ready`.
- **Reset values**
  - `presc`, all `cnt`, `db_level`, `pend`, `pol`, `ovf` = 0.
  - `ev_valid` = 0, `ev_ch` = 0, `ev_rise` = 0.
  - `last` = N_CH−1, so channel 0 has first priority.
  - Reset asserted mid-operation drops all pending and in-flight events, with no handshake.

## Timing
- All outputs are registered.
- `db_level` changes on the edge that ends the K-th tick cycle.
- `pend` is set on that same edge.
- The earliest `ev_valid` comes one cycle after `pend` is set.
- Worst-case latency from a stable input change to `db_level` is K·2^P cycles, plus the synchronizer delay when that option is enabled.
- Throughput: one event per cycle while `ev_ready` is held high.
- With all N_CH channels pending, each channel is granted within N_CH grants.

## Configuration
- `DEBOUNCE_SYNC_EN`
  - Defined: each `sw` bit passes through a 2-flop synchronizer (reset 0) before the integrator. This adds 2 cycles of latency.
  - Undefined: `sw` feeds the integrators directly. The inputs must then already be synchronous to `clk`.

## Structure
- Package `debounce_pkg`:
  - default values for N_CH, P and K;
  - the `ev_t` packed struct {ch, rise};
  - function `rr_next(pend, last)`, which returns the granted index.
- Sub-module `debounce_ch`: one integrator per channel (`tick`, `sw`, `db_level`, `evt`), instantiated N_CH times by a generate loop.
- Prescaler, pending slots, arbiter and output register live in the top module.

## Test plan
All scenarios use P=2 and K=3, so there is a tick every 4 cycles.
1. Reset, then hold `sw = 4'b0001`.
   - `db_level[0]` rises on the 3rd tick.
   - One event: `ev_ch = 0`, `ev_rise = 1`.
2. Glitch `sw[1]` high for 2 ticks, then low.
   - `db_level` stays 0.
   - No `ev_valid`.
3. Toggle `sw[3:0]` all high simultaneously, with `ev_ready = 1`.
   - 4 consecutive `ev_valid` cycles, channels 0, 1, 2, 3.
4. Same as scenario 3, with `ev_ready = 0` for 10 cycles.
   - `ev_ch = 0` is held stable throughout.
   - After release, the order is 1, 2, 3.
   - Then a second burst begins with channel 0, showing the rotation.
5. Hold `ev_ready = 0`. Drive channel 2 rise, then fall (K ticks each).
   - `ovf[2] = 1`; the delivered event is channel 2 with `ev_rise = 0`.
   - `ovf_clr` then clears `ovf[2]`.
6. Assert `reset` while `ev_valid = 1` and other events are pending.
   - The next cycle shows all outputs at reset values.
   - No stale events after reset deasserts.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared defaults, event record and round-robin helper for the debounce scheduler.
package debounce_pkg;

    localparam int N_CH_DEF = 4;
    localparam int P_DEF    = 16;
    localparam int K_DEF    = 4;
    localparam int CH_MAX_W = 4;

    typedef struct packed {
        logic [CH_MAX_W-1:0] ch;
        logic                rise;
    } ev_t;

    // First set bit of pend searching from last+1 upward, wrapping modulo n.
    function automatic logic [CH_MAX_W-1:0] rr_next(input logic [15:0] pend,
                                                    input logic [CH_MAX_W-1:0] last,
                                                    input int n);
        logic [CH_MAX_W-1:0] g;
        logic                found;
        int                  idx;
        g     = last;
        found = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            idx = (int'(last) + i) % n;
            if (!found && i <= n && pend[idx[3:0]]) begin
                g     = idx[CH_MAX_W-1:0];
                found = 1'b1;
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/debounce_ch.sv
// Single-channel debounce integrator: toggles its level on the K-th consecutive differing sample.
module debounce_ch
    import debounce_pkg::*;
#(
    parameter int K = K_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic sw,
    output logic db_level,
    output logic evt
);

    localparam int CNT_W = (K > 1) ? $clog2(K) : 1;

    logic [CNT_W-1:0] cnt;
    logic             differ;
    logic             at_term;

    assign differ  = (sw != db_level);
    assign at_term = (cnt == CNT_W'(K - 1));
    // Event is combinational so the top can latch it on the same edge the level toggles.
    assign evt     = tick && differ && at_term;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt      <= '0;
            db_level <= 1'b0;
        end else if (tick) begin
            if (!differ) begin
                cnt <= '0;
            end else if (at_term) begin
                db_level <= ~db_level;
                cnt      <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/debounce_sched.sv
// Multi-channel debounce with shared prescaler and round-robin event serializer.
// Optional input synchronizers enabled by defining DEBOUNCE_SYNC_EN.
module debounce_sched
    import debounce_pkg::*;
#(
    parameter  int N_CH = N_CH_DEF,
    parameter  int P    = P_DEF,
    parameter  int K    = K_DEF,
    localparam int CW   = $clog2(N_CH)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] sw,
    output logic [N_CH-1:0] db_level,
    output logic            ev_valid,
    input  logic            ev_ready,
    output logic [CW-1:0]   ev_ch,
    output logic            ev_rise,
    output logic [N_CH-1:0] ovf,
    input  logic            ovf_clr
);

    logic [P-1:0]          presc;
    logic                  tick;
    logic [N_CH-1:0]       sw_s;
    logic [N_CH-1:0]       evt;
    logic [N_CH-1:0]       pend, pend_n;
    logic [N_CH-1:0]       pol, pol_n;
    logic [N_CH-1:0]       ovf_n;
    logic [CH_MAX_W-1:0]   last;
    logic                  out_free;
    logic                  grant;
    logic [CW-1:0]         g;
    logic [N_CH-1:0]       gnt_vec;
    ev_t                   nxt_ev;

    assign tick = (presc == {P{1'b1}});

    always_ff @(posedge clk) begin
        if (reset) presc <= '0;
        else       presc <= presc + 1'b1;
    end

`ifdef DEBOUNCE_SYNC_EN
    logic [N_CH-1:0] sync_q1, sync_q2;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= sw;
            sync_q2 <= sync_q1;
        end
    end
    assign sw_s = sync_q2;
`else
    assign sw_s = sw;
`endif

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        debounce_ch #(.K(K)) u_ch (
            .clk      (clk),
            .reset    (reset),
            .tick     (tick),
            .sw       (sw_s[i]),
            .db_level (db_level[i]),
            .evt      (evt[i])
        );
    end

    assign out_free    = !ev_valid || ev_ready;
    assign grant       = out_free && (|pend);
    assign nxt_ev.ch   = rr_next(16'(pend), last, N_CH);
    assign g           = nxt_ev.ch[CW-1:0];
    assign nxt_ev.rise = pol[g];
    assign gnt_vec     = grant ? (N_CH'(1) << g) : '0;

    // A new edge on a channel being granted refills its slot without counting as overrun.
    always_comb begin
        pend_n = pend & ~gnt_vec;
        pol_n  = pol;
        ovf_n  = ovf_clr ? '0 : ovf;
        for (int i = 0; i < N_CH; i++) begin
            if (evt[i]) begin
                pend_n[i] = 1'b1;
                pol_n[i]  = ~db_level[i];
                if (pend[i] && !gnt_vec[i]) ovf_n[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pend <= '0;
            pol  <= '0;
            ovf  <= '0;
        end else begin
            pend <= pend_n;
            pol  <= pol_n;
            ovf  <= ovf_n;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ev_valid <= 1'b0;
            ev_ch    <= '0;
            ev_rise  <= 1'b0;
            last     <= CH_MAX_W'(N_CH - 1);
        end else if (out_free) begin
            ev_valid <= grant;
            if (grant) begin
                ev_ch   <= g;
                ev_rise <= nxt_ev.rise;
                last    <= nxt_ev.ch;
            end
        end
    end

endmodule

// File: tb/tb_debounce_sched.sv
// Directed bench for debounce_sched with P=2, K=3 (tick every 4 cycles).
module tb_debounce_sched;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] sw;
    logic [3:0] db_level;
    logic       ev_valid;
    logic       ev_ready;
    logic [1:0] ev_ch;
    logic       ev_rise;
    logic [3:0] ovf;
    logic       ovf_clr;

    int n_cmp = 0;
    int n_err = 0;

    debounce_sched #(.N_CH(4), .P(2), .K(3)) dut (
        .clk      (clk),
        .reset    (reset),
        .sw       (sw),
        .db_level (db_level),
        .ev_valid (ev_valid),
        .ev_ready (ev_ready),
        .ev_ch    (ev_ch),
        .ev_rise  (ev_rise),
        .ovf      (ovf),
        .ovf_clr  (ovf_clr)
    );

    always #5 clk = ~clk;

    // Leaves the bench on a negedge with presc == 0; edge k afterwards samples a tick when k%4 == 0.
    task automatic do_reset();
        reset    = 1'b1;
        sw       = 4'b0000;
        ev_ready = 1'b0;
        ovf_clr  = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        sw       = 4'b1111;
        ev_ready = 1'b1;
        ovf_clr  = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (db_level !== 4'b0000) begin n_err++; $display("FAIL reset db_level got %b want 0000", db_level); end
        n_cmp++; if (ev_valid !== 1'b0) begin n_err++; $display("FAIL reset ev_valid got %b want 0", ev_valid); end
        n_cmp++; if (ev_ch !== 2'd0) begin n_err++; $display("FAIL reset ev_ch got %0d want 0", ev_ch); end
        n_cmp++; if (ev_rise !== 1'b0) begin n_err++; $display("FAIL reset ev_rise got %b want 0", ev_rise); end
        n_cmp++; if (ovf !== 4'b0000) begin n_err++; $display("FAIL reset ovf got %b want 0000", ovf); end
    endtask

    task automatic test_single();
        logic [3:0] e_db;
        logic       e_v;
        do_reset();
        sw = 4'b0001;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            e_db = (k >= 12) ? 4'b0001 : 4'b0000;
            e_v  = (k == 13);
            n_cmp++; if (db_level !== e_db) begin n_err++; $display("FAIL single db_level k=%0d got %b want %b", k, db_level, e_db); end
            n_cmp++; if (ev_valid !== e_v) begin n_err++; $display("FAIL single ev_valid k=%0d got %b want %b", k, ev_valid, e_v); end
            if (e_v) begin
                n_cmp++; if (ev_ch !== 2'd0 || ev_rise !== 1'b1) begin n_err++; $display("FAIL single event k=%0d got ch%0d rise%b want ch0 rise1", k, ev_ch, ev_rise); end
                ev_ready = 1'b1;
            end
        end
    endtask

    task automatic test_glitch();
        do_reset();
        ev_ready = 1'b1;
        for (int k = 1; k <= 28; k++) begin
            sw = ((k <= 8) || (k >= 13 && k <= 20)) ? 4'b0010 : 4'b0000;
            @(negedge clk);
            n_cmp++; if (db_level !== 4'b0000) begin n_err++; $display("FAIL glitch db_level k=%0d got %b want 0000", k, db_level); end
            n_cmp++; if (ev_valid !== 1'b0) begin n_err++; $display("FAIL glitch ev_valid k=%0d got %b want 0", k, ev_valid); end
        end
    endtask

    task automatic test_burst();
        logic [3:0] e_db;
        logic       e_v;
        do_reset();
        ev_ready = 1'b1;
        sw       = 4'b1111;
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            e_db = (k >= 12) ? 4'b1111 : 4'b0000;
            e_v  = (k >= 13 && k <= 16);
            n_cmp++; if (db_level !== e_db) begin n_err++; $display("FAIL burst db_level k=%0d got %b want %b", k, db_level, e_db); end
            n_cmp++; if (ev_valid !== e_v) begin n_err++; $display("FAIL burst ev_valid k=%0d got %b want %b", k, ev_valid, e_v); end
            if (e_v) begin
                n_cmp++; if (ev_ch !== 2'(k - 13) || ev_rise !== 1'b1) begin n_err++; $display("FAIL burst event k=%0d got ch%0d rise%b want ch%0d rise1", k, ev_ch, ev_rise, k - 13); end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] e_db;
        logic       e_v;
        logic [1:0] e_ch;
        logic       e_r;
        do_reset();
        sw = 4'b1111;
        for (int k = 1; k <= 41; k++) begin
            @(negedge clk);
            e_db = (k < 12) ? 4'b0000 : (k < 36) ? 4'b1111 : 4'b0000;
            e_v  = (k >= 13 && k <= 25) || (k >= 37 && k <= 40);
            e_ch = (k <= 22) ? 2'd0 : (k <= 25) ? 2'(k - 22) : 2'(k - 37);
            e_r  = (k < 30);
            n_cmp++; if (db_level !== e_db) begin n_err++; $display("FAIL b2b db_level k=%0d got %b want %b", k, db_level, e_db); end
            n_cmp++; if (ev_valid !== e_v) begin n_err++; $display("FAIL b2b ev_valid k=%0d got %b want %b", k, ev_valid, e_v); end
            n_cmp++; if (ovf !== 4'b0000) begin n_err++; $display("FAIL b2b ovf k=%0d got %b want 0000", k, ovf); end
            if (e_v) begin
                n_cmp++; if (ev_ch !== e_ch || ev_rise !== e_r) begin n_err++; $display("FAIL b2b event k=%0d got ch%0d rise%b want ch%0d rise%b", k, ev_ch, ev_rise, e_ch, e_r); end
            end
            if (k == 22) ev_ready = 1'b1;
            if (k == 26) sw = 4'b0000;
        end
    endtask

    task automatic test_overrun();
        logic [3:0] e_db;
        logic [3:0] e_ovf;
        logic       e_v;
        logic [1:0] e_ch;
        logic       e_r;
        do_reset();
        sw = 4'b0001;
        for (int k = 1; k <= 39; k++) begin
            @(negedge clk);
            e_db  = (k < 12) ? 4'b0000 : (k < 24) ? 4'b0001 : (k < 36) ? 4'b0101 : 4'b0001;
            e_ovf = (k >= 36 && k <= 38) ? 4'b0100 : 4'b0000;
            e_v   = (k >= 13 && k <= 37);
            e_ch  = (k == 37) ? 2'd2 : 2'd0;
            e_r   = (k != 37);
            n_cmp++; if (db_level !== e_db) begin n_err++; $display("FAIL ovf db_level k=%0d got %b want %b", k, db_level, e_db); end
            n_cmp++; if (ovf !== e_ovf) begin n_err++; $display("FAIL ovf flags k=%0d got %b want %b", k, ovf, e_ovf); end
            n_cmp++; if (ev_valid !== e_v) begin n_err++; $display("FAIL ovf ev_valid k=%0d got %b want %b", k, ev_valid, e_v); end
            if (e_v) begin
                n_cmp++; if (ev_ch !== e_ch || ev_rise !== e_r) begin n_err++; $display("FAIL ovf event k=%0d got ch%0d rise%b want ch%0d rise%b", k, ev_ch, ev_rise, e_ch, e_r); end
            end
            if (k == 12) sw = 4'b0101;
            if (k == 24) sw = 4'b0001;
            if (k == 36) ev_ready = 1'b1;
            ovf_clr = (k == 38);
        end
        ovf_clr = 1'b0;
    endtask

    task automatic test_reset_midop();
        do_reset();
        sw = 4'b1111;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (k >= 13) begin
                n_cmp++; if (ev_valid !== 1'b1 || ev_ch !== 2'd0) begin n_err++; $display("FAIL midop pre event k=%0d got v%b ch%0d want v1 ch0", k, ev_valid, ev_ch); end
            end
        end
        reset = 1'b1;
        @(negedge clk);
        n_cmp++; if (ev_valid !== 1'b0) begin n_err++; $display("FAIL midop ev_valid got %b want 0", ev_valid); end
        n_cmp++; if (ev_ch !== 2'd0 || ev_rise !== 1'b0) begin n_err++; $display("FAIL midop ev_ch/rise got %0d/%b want 0/0", ev_ch, ev_rise); end
        n_cmp++; if (db_level !== 4'b0000 || ovf !== 4'b0000) begin n_err++; $display("FAIL midop db/ovf got %b/%b want 0000/0000", db_level, ovf); end
        reset    = 1'b0;
        sw       = 4'b0000;
        ev_ready = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            n_cmp++; if (ev_valid !== 1'b0 || db_level !== 4'b0000) begin n_err++; $display("FAIL midop stale k=%0d got v%b db%b want v0 db0000", k, ev_valid, db_level); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_glitch();
        test_burst();
        test_back_to_back();
        test_overrun();
        test_reset_midop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
